// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-compatible bus responder:
// opcode masks, display geometry, FSM states and the AC-to-RAM index map.
package lcd_pkg;

  // Instruction opcode masks; an instruction is identified by its highest set bit.
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_ENTRY    = 8'h04;
  localparam logic [7:0] CMD_DISPLAY  = 8'h08;
  localparam logic [7:0] CMD_SHIFT    = 8'h10;
  localparam logic [7:0] CMD_FUNCTION = 8'h20;
  localparam logic [7:0] CMD_CGRAM    = 8'h40;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;

  // DDRAM geometry of a 2x16 panel.
  localparam logic [6:0] LINE1_BASE    = 7'h00;
  localparam logic [6:0] LINE2_BASE    = 7'h40;
  localparam logic [6:0] LINE_LEN      = 7'd16;
  localparam logic [6:0] LINE1_LAST_2L = 7'h27;  // last AC of line 1 in two-line mode
  localparam logic [6:0] LINE2_LAST_2L = 7'h67;  // last AC of line 2 in two-line mode
  localparam logic [6:0] LAST_1L       = 7'h4F;  // last AC in one-line mode

  localparam logic [7:0] SPACE     = 8'h20;
  localparam int         RAM_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } lcd_state_e;

  // One synchronised sample of the LCD bus.
  typedef struct packed {
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_sample_t;

  // Shadow-RAM location addressed by an AC value.
  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } ram_idx_t;

  // Map a DDRAM address onto the 32-byte shadow RAM (line 1 -> 0..15, line 2 -> 16..31).
  function automatic ram_idx_t ac_to_idx(input logic [6:0] ac);
    ram_idx_t   r;
    logic [6:0] off1;
    logic [6:0] off2;
    off1 = ac - LINE1_BASE;
    off2 = ac - LINE2_BASE;
    r    = '0;
    if (off1 < LINE_LEN) begin
      r.valid = 1'b1;
      r.idx   = off1[4:0];
    end else if (off2 < LINE_LEN) begin
      r.valid = 1'b1;
      r.idx   = off2[4:0] + LINE_LEN[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Combinational next value of the DDRAM address counter for a +1/-1 step,
// applying the one-line / two-line wrap rules. Out-of-range AC steps to 0.
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [6:0] ac_i,
  input  logic       dir_i,       // 1 = increment, 0 = decrement
  input  logic       two_line_i,
  output logic [6:0] ac_o
);

  // Wrap-aware step; every path starts from the "illegal AC -> 0" default.
  always_comb begin
    ac_o = 7'h00;
    if (two_line_i) begin
      if (ac_i <= LINE1_LAST_2L || (ac_i >= LINE2_BASE && ac_i <= LINE2_LAST_2L)) begin
        if (dir_i) begin
          if (ac_i == LINE1_LAST_2L)      ac_o = LINE2_BASE;
          else if (ac_i == LINE2_LAST_2L) ac_o = LINE1_BASE;
          else                            ac_o = ac_i + 7'd1;
        end else begin
          if (ac_i == LINE2_BASE)         ac_o = LINE1_LAST_2L;
          else if (ac_i == LINE1_BASE)    ac_o = LINE2_LAST_2L;
          else                            ac_o = ac_i - 7'd1;
        end
      end
    end else if (ac_i <= LAST_1L) begin
      if (dir_i) ac_o = (ac_i == LAST_1L)    ? LINE1_BASE : ac_i + 7'd1;
      else       ac_o = (ac_i == LINE1_BASE) ? LAST_1L    : ac_i - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder on the 8-bit character-LCD bus. Decodes
// instructions and data, mirrors the 2x16 display in a 32-byte shadow RAM,
// emulates the busy flag, answers bus reads and exposes a host read port.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 2000,
  parameter int CLR_CYCLES  = 82000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  output logic [7:0] oLCD_DQ,
  output logic       oLCD_DQ_OE,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_DATA,
  output logic       oBusy,
  output logic [6:0] oAddr,
  output logic       oDispOn,
  output logic       oCursorOn,
  output logic       oBlinkOn,
  output logic       oTwoLine,
  output logic       oWrStb,
  output logic       oOverrun
);

  localparam int CNT_MAX  = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int CLR_TAIL = CLR_CYCLES - RAM_DEPTH;  // busy time left after the fill pass

  localparam logic [CW-1:0] BUSY_LOAD     = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] HOME_LOAD     = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] CLR_TAIL_LOAD = CW'((CLR_TAIL > 0) ? CLR_TAIL - 1 : 0);
  localparam logic [4:0]    FILL_LAST     = 5'(RAM_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Bus synchroniser: all lines share one chain so they keep equal delay.
  bus_sample_t [SYNC_STAGES-1:0] sync_q;
  bus_sample_t                   bus_s;
  bus_sample_t                   bus_prev_q;

  // Synchroniser chain plus one extra stage holding the sample before the current one.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_q     <= '0;
      bus_prev_q <= '0;
    end else begin
      sync_q[0] <= '{en: LCD_EN, rs: LCD_RS, rw: LCD_RW, data: LCD_DATA};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bus_prev_q <= bus_s;
    end
  end

  assign bus_s = sync_q[SYNC_STAGES-1];

  // Falling edge of synced EN; RS/RW/DATA come from the last EN-high sample.
  logic       strobe;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [7:0] cmd;

  assign strobe    = bus_prev_q.en & ~bus_s.en;
  assign wr_strobe = strobe & ~bus_prev_q.rw;
  assign rd_strobe = strobe &  bus_prev_q.rw;
  assign cmd       = bus_prev_q.data;

  // ---------------------------------------------------------------------------
  // State
  lcd_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  fill_q, fill_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic        s_q, s_d;
  logic        disp_q, disp_d;
  logic        cursor_q, cursor_d;
  logic        blink_q, blink_d;
  logic        two_line_q, two_line_d;
  logic        cgram_q, cgram_d;
  logic        init_q, init_d;      // RAM refill pending/running after reset
  logic        wr_stb_q, wr_stb_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rd_data_q;

  logic        busy;
  logic        blocked;
  assign busy    = (state_q != ST_IDLE);
  assign blocked = busy | init_q;

  // ---------------------------------------------------------------------------
  // Shadow RAM: one write port, bus and host read ports.
  logic [7:0] ram_q [RAM_DEPTH];
  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;

  // NOTE: the memory array has no reset; after reset a CLEAR pass refills it with spaces.
  always_ff @(posedge iCLK) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  // Registered host read; a same-cycle write to the same index yields the old byte.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rd_data_q <= '0;
    else         rd_data_q <= ram_q[iRD_ADDR];
  end

  ram_idx_t   bus_idx;
  logic [7:0] bus_ram_byte;
  assign bus_idx      = ac_to_idx(ac_q);
  assign bus_ram_byte = bus_idx.valid ? ram_q[bus_idx.idx] : SPACE;

  // ---------------------------------------------------------------------------
  // AC stepping: data accesses step by I/D, cursor shift by its R/L bit.
  logic       step_dir;
  logic [6:0] ac_stepped;
  assign step_dir = bus_prev_q.rs ? id_q : cmd[2];

  lcd_ac_step u_ac_step (
    .ac_i       (ac_q),
    .dir_i      (step_dir),
    .two_line_i (two_line_q),
    .ac_o       (ac_stepped)
  );

  // ---------------------------------------------------------------------------
  // State register for the FSM and all architectural registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      s_q        <= 1'b0;
      disp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      blink_q    <= 1'b0;
      two_line_q <= 1'b0;
      cgram_q    <= 1'b0;
      init_q     <= 1'b1;
      wr_stb_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      s_q        <= s_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      blink_q    <= blink_d;
      two_line_q <= two_line_d;
      cgram_q    <= cgram_d;
      init_q     <= init_d;
      wr_stb_q   <= wr_stb_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state: busy timing, clear fill, instruction decode and data accesses.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    ac_d       = ac_q;
    id_d       = id_q;
    s_d        = s_q;
    disp_d     = disp_q;
    cursor_d   = cursor_q;
    blink_d    = blink_q;
    two_line_d = two_line_q;
    cgram_d    = cgram_q;
    init_d     = init_q;
    wr_stb_d   = 1'b0;
    overrun_d  = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = bus_idx.idx;
    ram_wdata  = cmd;

    unique case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          state_d = ST_CLEAR;
          fill_d  = '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = fill_q;
        ram_wdata = SPACE;
        if (fill_q == FILL_LAST) begin
          if (init_q) begin
            state_d = ST_IDLE;
            init_d  = 1'b0;
          end else if (CLR_TAIL > 0) begin
            state_d = ST_EXEC;
            cnt_d   = CLR_TAIL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fill_d = fill_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_strobe) begin
      if (blocked) begin
        overrun_d = 1'b1;
      end else begin
        state_d = ST_EXEC;
        cnt_d   = BUSY_LOAD;
        if (bus_prev_q.rs) begin
          if (!cgram_q) begin
            if (bus_idx.valid) begin
              ram_we    = 1'b1;
              ram_waddr = bus_idx.idx;
              ram_wdata = cmd;
              wr_stb_d  = 1'b1;
            end
            ac_d = ac_stepped;
          end
        end else if (|(cmd & CMD_DDRAM)) begin
          ac_d    = cmd[6:0];
          cgram_d = 1'b0;
        end else if (|(cmd & CMD_CGRAM)) begin
          cgram_d = 1'b1;
        end else if (|(cmd & CMD_FUNCTION)) begin
          two_line_d = cmd[3];
        end else if (|(cmd & CMD_SHIFT)) begin
          if (!cmd[3]) ac_d = ac_stepped;
        end else if (|(cmd & CMD_DISPLAY)) begin
          disp_d   = cmd[2];
          cursor_d = cmd[1];
          blink_d  = cmd[0];
        end else if (|(cmd & CMD_ENTRY)) begin
          id_d = cmd[1];
          s_d  = cmd[0];
        end else if (|(cmd & CMD_HOME)) begin
          ac_d  = '0;
          cnt_d = HOME_LOAD;
        end else if (|(cmd & CMD_CLEAR)) begin
          ac_d    = '0;
          id_d    = 1'b1;
          state_d = ST_CLEAR;
          fill_d  = '0;
        end
      end
    end else if (rd_strobe && bus_prev_q.rs) begin
      ac_d = ac_stepped;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  assign oLCD_DQ_OE = bus_s.en & bus_s.rw;
  assign oLCD_DQ    = oLCD_DQ_OE ? (bus_s.rs ? bus_ram_byte : {busy, ac_q}) : 8'h00;
  assign oRD_DATA   = rd_data_q;
  assign oBusy      = busy;
  assign oAddr      = ac_q;
  assign oDispOn    = disp_q;
  assign oCursorOn  = cursor_q;
  assign oBlinkOn   = blink_q;
  assign oTwoLine   = two_line_q;
  assign oWrStb     = wr_stb_q;
  assign oOverrun   = overrun_q;

endmodule
